conv_sequencer: RTL and testbench

- Parametrised control FSM for the convolution datapath; replaces the fixed 3-tap, single-channel convolution controller.
- Sequences coefficient loading, kernel-row fill and streaming convolution for a K-row kernel over NUM_CH channels.
- Adds new-row refill, a coefficient-valid interlock with an error flag, and per-channel convolve passes.
- Sits between the host-facing load interface and the sample shift register, coefficient register file and MAC.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_sequencer_if.sv | 41 ++++
 rtl/conv_sequencer_flex_counter.sv | 31 +++
 rtl/conv_sequencer.sv | 143 ++++++++++++++
 tb/tb_conv_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencer.
//   state_t   : sequencer FSM states
//   max_width : index width for a counter covering 0..n-1, never below 1 bit
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COEFF,
      FILL_WAIT,
      FILL_SHIFT,
      CONV,
      STREAM_WAIT,
      STREAM_SHIFT
   } state_t;

   function automatic int max_width(input int n);
      return ($clog2(n) > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// Host/datapath control bundle of the convolution sequencer.
//   Host requests  : sample_load_en, new_row, coeff_load_en
//   Control strobes: modwait, sample_shift, sample_stream, convolve_en, coeff_ld
//   Indices        : coeff_sel [SEL_W], ch_sel [CH_W]
//   Status         : coeff_valid, err
// master = host side (drives requests), slave = sequencer side.
interface conv_sequencer_if #(
   parameter int K      = 3,
   parameter int NUM_CH = 1
);
   import conv_pkg::*;

   localparam int SEL_W = max_width(K);
   localparam int CH_W  = max_width(NUM_CH);

   logic             sample_load_en;
   logic             new_row;
   logic             coeff_load_en;
   logic             modwait;
   logic             sample_shift;
   logic             sample_stream;
   logic             convolve_en;
   logic             coeff_ld;
   logic [SEL_W-1:0] coeff_sel;
   logic [CH_W-1:0]  ch_sel;
   logic             coeff_valid;
   logic             err;

   modport master (
      output sample_load_en, new_row, coeff_load_en,
      input  modwait, sample_shift, sample_stream, convolve_en, coeff_ld,
             coeff_sel, ch_sel, coeff_valid, err
   );

   modport slave (
      input  sample_load_en, new_row, coeff_load_en,
      output modwait, sample_shift, sample_stream, convolve_en, coeff_ld,
             coeff_sel, ch_sel, coeff_valid, err
   );

endinterface

// File: rtl/conv_sequencer_flex_counter.sv
// flex_counter: parametrised rollover counter.
//   clk, n_rst    : clock, asynchronous active-low reset
//   clear         : synchronous clear, wins over count_enable
//   count_enable  : advance by one, wrapping ROLLOVER-1 -> 0
//   count_out     : current count
//   rollover_flag : count_out is at ROLLOVER-1 (next enabled edge wraps)
module flex_counter #(
   parameter int NUM_BITS = 4,
   parameter int ROLLOVER = 16
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                clear,
   input  logic                count_enable,
   output logic [NUM_BITS-1:0] count_out,
   output logic                rollover_flag
);

   assign rollover_flag = (count_out == NUM_BITS'(ROLLOVER - 1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_out <= '0;
      end else if (clear) begin
         count_out <= '0;
      end else if (count_enable) begin
         count_out <= rollover_flag ? '0 : count_out + NUM_BITS'(1);
      end
   end

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: control FSM for a K-row, NUM_CH-channel convolution.
// Sequences coefficient loading, kernel-row fill and streaming convolve
// passes, with new-row refill and a coefficient-valid interlock.
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : conv_sequencer_if.slave (requests in, strobes/indices/status out)
// All strobes are registered from the next state, so each is high exactly
// while the FSM sits in the corresponding state.
module conv_sequencer
   import conv_pkg::*;
#(
   parameter int    K      = 3,
   parameter int    NUM_CH = 1,
   localparam int   SEL_W  = max_width(K),
   localparam int   CH_W   = max_width(NUM_CH)
) (
   input  logic      clk,
   input  logic      n_rst,
   conv_sequencer_if.slave bus
);

   localparam int FC_W = $clog2(K + 1);

   state_t           state, state_nxt;
   logic [FC_W-1:0]  fill_cnt, fill_nxt;
   logic             coeff_valid_r, coeff_valid_nxt;
   logic             err_r, err_nxt;
   logic             modwait_r, sample_shift_r, sample_stream_r, convolve_en_r, coeff_ld_r;
   logic [SEL_W-1:0] coeff_sel;
   logic [CH_W-1:0]  ch_sel;
   logic             coeff_wrap, ch_wrap;
   logic             sel_clear, sel_en, ch_clear, ch_en;

   // Counters hold 0 outside their active states, so they start every
   // COEFF/CONV pass at 0 and read as 0 everywhere else. Enabled passes end
   // exactly on a rollover, which also leaves them at 0.
   assign sel_en    = (state == COEFF);
   assign sel_clear = (state != COEFF);
   assign ch_en     = (state == CONV) || ((state == COEFF) && coeff_wrap);
   assign ch_clear  = (state != COEFF) && (state != CONV);

   flex_counter #(.NUM_BITS(SEL_W), .ROLLOVER(K)) u_coeff_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (sel_clear),
      .count_enable  (sel_en),
      .count_out     (coeff_sel),
      .rollover_flag (coeff_wrap)
   );

   flex_counter #(.NUM_BITS(CH_W), .ROLLOVER(NUM_CH)) u_ch_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (ch_clear),
      .count_enable  (ch_en),
      .count_out     (ch_sel),
      .rollover_flag (ch_wrap)
   );

   always_comb begin
      state_nxt       = state;
      fill_nxt        = fill_cnt;
      coeff_valid_nxt = coeff_valid_r;
      err_nxt         = err_r;
      case (state)
         IDLE: begin
            if (bus.coeff_load_en) begin
               state_nxt = COEFF;
            end else if (bus.sample_load_en) begin
               if (coeff_valid_r) state_nxt = FILL_SHIFT;
               else               err_nxt   = 1'b1;
            end
         end
         COEFF: begin
            // Last (channel, coefficient) pair reached: the set is complete.
            if (coeff_wrap && ch_wrap) begin
               state_nxt       = IDLE;
               coeff_valid_nxt = 1'b1;
               err_nxt         = 1'b0;
               fill_nxt        = '0;
            end
         end
         FILL_SHIFT: begin
            fill_nxt  = fill_cnt + FC_W'(1);
            state_nxt = (fill_cnt == FC_W'(K - 1)) ? CONV : FILL_WAIT;
         end
         FILL_WAIT: begin
            if (bus.coeff_load_en)       state_nxt = COEFF;
            else if (bus.sample_load_en) state_nxt = FILL_SHIFT;
         end
         CONV: begin
            if (ch_wrap) state_nxt = STREAM_WAIT;
         end
         STREAM_WAIT: begin
            if (bus.coeff_load_en) begin
               state_nxt = COEFF;
            end else if (bus.new_row) begin
               state_nxt = FILL_WAIT;
               fill_nxt  = '0;
            end else if (bus.sample_load_en) begin
               state_nxt = STREAM_SHIFT;
            end
         end
         STREAM_SHIFT: state_nxt = CONV;
         default:      state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state           <= IDLE;
         fill_cnt        <= '0;
         coeff_valid_r   <= 1'b0;
         err_r           <= 1'b0;
         modwait_r       <= 1'b0;
         sample_shift_r  <= 1'b0;
         sample_stream_r <= 1'b0;
         convolve_en_r   <= 1'b0;
         coeff_ld_r      <= 1'b0;
      end else begin
         state           <= state_nxt;
         fill_cnt        <= fill_nxt;
         coeff_valid_r   <= coeff_valid_nxt;
         err_r           <= err_nxt;
         modwait_r       <= (state_nxt == COEFF) || (state_nxt == FILL_SHIFT) ||
                            (state_nxt == CONV)  || (state_nxt == STREAM_SHIFT);
         sample_shift_r  <= (state_nxt == FILL_SHIFT) || (state_nxt == STREAM_SHIFT);
         sample_stream_r <= (state_nxt == CONV);
         convolve_en_r   <= (state_nxt == CONV);
         coeff_ld_r      <= (state_nxt == COEFF);
      end
   end

   assign bus.modwait       = modwait_r;
   assign bus.sample_shift  = sample_shift_r;
   assign bus.sample_stream = sample_stream_r;
   assign bus.convolve_en   = convolve_en_r;
   assign bus.coeff_ld      = coeff_ld_r;
   assign bus.coeff_sel     = coeff_sel;
   assign bus.ch_sel        = ch_sel;
   assign bus.coeff_valid   = coeff_valid_r;
   assign bus.err           = err_r;

endmodule

// File: tb/tb_conv_sequencer.sv
// Testbench for conv_sequencer (K=3, NUM_CH=2): directed vector table,
// hand-written reset/interlock sequences, and random stimulus checked
// against a queue-based schedule model of the sequencer.
module tb_conv_sequencer;
   import conv_pkg::*;

   localparam int K      = 3;
   localparam int NUM_CH = 2;
   localparam int SEL_W  = max_width(K);
   localparam int CH_W   = max_width(NUM_CH);
   localparam int OW     = 7 + SEL_W + CH_W;

   logic tb_clk = 1'b0;
   logic n_rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 tb_clk = ~tb_clk;

   conv_sequencer_if #(.K(K), .NUM_CH(NUM_CH)) bus ();

   conv_sequencer #(.K(K), .NUM_CH(NUM_CH)) dut (
      .clk   (tb_clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   // {modwait, sample_shift, sample_stream, convolve_en, coeff_ld, coeff_sel, ch_sel, coeff_valid, err}
   logic [OW-1:0] obs;
   assign obs = {bus.modwait, bus.sample_shift, bus.sample_stream, bus.convolve_en,
                 bus.coeff_ld, bus.coeff_sel, bus.ch_sel, bus.coeff_valid, bus.err};

   function automatic logic [OW-1:0] pack(input bit mw, sh, cs, ld,
                                          input int csel, ch, input bit cv, er);
      return {mw, sh, cs, cs, ld, SEL_W'(csel), CH_W'(ch), cv, er};
   endfunction

   task automatic check(input string name, input logic [OW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b required %b", name, obs, exp);
      end
   endtask

   task automatic step(input bit cl, sl, nr);
      @(negedge tb_clk);
      bus.coeff_load_en  = cl;
      bus.sample_load_en = sl;
      bus.new_row        = nr;
      @(posedge tb_clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge tb_clk);
      n_rst              = 1'b0;
      bus.coeff_load_en  = 1'b0;
      bus.sample_load_en = 1'b0;
      bus.new_row        = 1'b0;
      repeat (2) @(posedge tb_clk);
      @(negedge tb_clk);
      n_rst = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit            cl, sl, nr;
      logic [OW-1:0] exp;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit cl, sl, nr, mw, sh, cs, ld,
                      input int csel, ch, input bit cv, er);
      vec_t v;
      v.cl  = cl;
      v.sl  = sl;
      v.nr  = nr;
      v.exp = pack(mw, sh, cs, ld, csel, ch, cv, er);
      tbl.push_back(v);
   endtask

   // ---------------- reference model ----------------
   // Busy phases are scheduled as a queue of per-cycle outputs when a
   // request is accepted; requests are only looked at while the queue is
   // empty, and the resting behaviour depends on where the kernel fill is.
   typedef enum {R_IDLE, R_FILL, R_STREAM} rest_t;
   logic [OW-1:0] mq[$];
   rest_t         m_rest;
   int            m_fill;
   bit            m_cv, m_err;

   function automatic void m_reset();
      mq.delete();
      m_rest = R_IDLE;
      m_fill = 0;
      m_cv   = 1'b0;
      m_err  = 1'b0;
   endfunction

   function automatic void m_push_coeff();
      for (int ch = 0; ch < NUM_CH; ch++)
         for (int c = 0; c < K; c++)
            mq.push_back(pack(1, 0, 0, 1, c, ch, m_cv, m_err));
      m_cv   = 1'b1;
      m_err  = 1'b0;
      m_fill = 0;
      m_rest = R_IDLE;
   endfunction

   function automatic void m_push_conv();
      for (int ch = 0; ch < NUM_CH; ch++)
         mq.push_back(pack(1, 0, 1, 0, 0, ch, m_cv, m_err));
      m_rest = R_STREAM;
   endfunction

   function automatic void m_edge(input bit cl, sl, nr);
      if (mq.size() != 0) begin
         mq.delete(0);
         return;
      end
      if (cl) begin
         m_push_coeff();
      end else if (m_rest == R_STREAM && nr) begin
         m_fill = 0;
         m_rest = R_FILL;
      end else if (sl) begin
         if (m_rest == R_STREAM) begin
            mq.push_back(pack(1, 1, 0, 0, 0, 0, m_cv, m_err));
            m_push_conv();
         end else if (!m_cv) begin
            m_err = 1'b1;
         end else begin
            mq.push_back(pack(1, 1, 0, 0, 0, 0, m_cv, m_err));
            m_fill++;
            if (m_fill == K) m_push_conv();
            else             m_rest = R_FILL;
         end
      end
   endfunction

   function automatic logic [OW-1:0] m_exp();
      return (mq.size() != 0) ? mq[0] : pack(0, 0, 0, 0, 0, 0, m_cv, m_err);
   endfunction

   initial begin
      bit cl, sl, nr;
      n_rst              = 1'b0;
      bus.coeff_load_en  = 1'b0;
      bus.sample_load_en = 1'b0;
      bus.new_row        = 1'b0;

      do_reset();
      check("reset", pack(0, 0, 0, 0, 0, 0, 0, 0));

      //  cl sl nr | mw sh cs ld csel ch cv er
      add(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 1);   // interlock: err, no shift
      add(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
      add(1, 0, 0,  1, 0, 0, 1, 0, 0, 0, 1);   // coefficient load
      add(0, 1, 1,  1, 0, 0, 1, 1, 0, 0, 1);
      add(1, 1, 0,  1, 0, 0, 1, 2, 0, 0, 1);
      add(0, 0, 0,  1, 0, 0, 1, 0, 1, 0, 1);
      add(0, 1, 0,  1, 0, 0, 1, 1, 1, 0, 1);
      add(0, 0, 0,  1, 0, 0, 1, 2, 1, 0, 1);
      add(0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);   // set valid, err cleared
      add(0, 1, 0,  1, 1, 0, 0, 0, 0, 1, 0);   // fill with sample_load_en held
      add(0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 1, 0,  1, 1, 0, 0, 0, 0, 1, 0);
      add(0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 1, 0,  1, 1, 0, 0, 0, 0, 1, 0);
      add(0, 1, 0,  1, 0, 1, 0, 0, 0, 1, 0);   // convolve ch0
      add(0, 0, 0,  1, 0, 1, 0, 0, 1, 1, 0);   // convolve ch1
      add(0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);   // stream wait, idle inputs
      add(0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 1, 0,  1, 1, 0, 0, 0, 0, 1, 0);   // stream shift
      add(0, 0, 0,  1, 0, 1, 0, 0, 0, 1, 0);
      add(0, 0, 0,  1, 0, 1, 0, 0, 1, 1, 0);
      add(0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 1, 1,  0, 0, 0, 0, 0, 0, 1, 0);   // new_row beats sample_load_en
      add(0, 1, 0,  1, 1, 0, 0, 0, 0, 1, 0);   // refill: 3 shifts
      add(0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 1, 0,  1, 1, 0, 0, 0, 0, 1, 0);
      add(0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 1, 0,  1, 1, 0, 0, 0, 0, 1, 0);
      add(0, 0, 0,  1, 0, 1, 0, 0, 0, 1, 0);
      add(0, 0, 0,  1, 0, 1, 0, 0, 1, 1, 0);
      add(0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
      add(1, 1, 1,  1, 0, 0, 1, 0, 0, 1, 0);   // coeff_load_en has priority
      add(0, 0, 0,  1, 0, 0, 1, 1, 0, 1, 0);
      add(0, 0, 0,  1, 0, 0, 1, 2, 0, 1, 0);
      add(0, 0, 0,  1, 0, 0, 1, 0, 1, 1, 0);
      add(0, 0, 0,  1, 0, 0, 1, 1, 1, 1, 0);
      add(0, 0, 0,  1, 0, 0, 1, 2, 1, 1, 0);
      add(0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 1,  0, 0, 0, 0, 0, 0, 1, 0);   // new_row ignored in IDLE
      add(0, 1, 0,  1, 1, 0, 0, 0, 0, 1, 0);   // fill restarts from 0

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].cl, tbl[i].sl, tbl[i].nr);
         check($sformatf("vec%0d", i), tbl[i].exp);
      end

      // Asynchronous reset on the second coefficient-load cycle
      step(0, 0, 0);
      check("fill_wait", pack(0, 0, 0, 0, 0, 0, 1, 0));
      step(1, 0, 0);
      check("coeff_ld_1", pack(1, 0, 0, 1, 0, 0, 1, 0));
      step(0, 0, 0);
      check("coeff_ld_2", pack(1, 0, 0, 1, 1, 0, 1, 0));
      #2 n_rst = 1'b0;
      #1 check("async_reset", pack(0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge tb_clk);
      @(negedge tb_clk);
      n_rst = 1'b1;
      check("reset_release", pack(0, 0, 0, 0, 0, 0, 0, 0));
      step(0, 1, 0);
      check("interlock_after_reset", pack(0, 0, 0, 0, 0, 0, 0, 1));
      step(1, 0, 0);
      check("reload_start", pack(1, 0, 0, 1, 0, 0, 0, 1));
      repeat (K * NUM_CH) step(0, 0, 0);
      check("err_cleared", pack(0, 0, 0, 0, 0, 0, 1, 0));

      // Random stimulus against the schedule model
      do_reset();
      m_reset();
      for (int i = 0; i < 3000; i++) begin
         cl = ($urandom_range(15) == 0);
         sl = ($urandom_range(1) == 1);
         nr = ($urandom_range(7) == 0);
         step(cl, sl, nr);
         m_edge(cl, sl, nr);
         check($sformatf("random%0d", i), m_exp());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
